// File: rtl/seg_display_ctrl.sv
// Front-panel debug controller: two debounced buttons step the datapath probe
// selector, and the probed 32-bit value is scanned out as eight hex digits.
module seg_display_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SCAN_DIV        = 100000,
   parameter int NUM_SEL         = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_sel,
   input  logic        btn_reg,
   input  logic [31:0] disdata,
   output logic [8:0]  cn3,
   output logic [7:0]  an,
   output logic [7:0]  seg
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int SW = $clog2(SCAN_DIV);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [SW-1:0] PRE_LAST = SW'(SCAN_DIV - 1);
   localparam logic [3:0]    SEL_LAST = 4'(NUM_SEL - 1);

   function automatic logic [7:0] hex_seg(input logic [3:0] nib);
      logic [7:0] s;
      case (nib)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   // Bit 0 is the select button, bit 1 the register-index button.
   logic [1:0] btn_raw;
   logic [1:0] pulse;
   assign btn_raw = {btn_reg, btn_sel};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         logic          meta_q;
         logic          sync_q;
         logic          level_q;
         logic          level_dly_q;
         logic [DW-1:0] cnt_q;

         // A level change is accepted only after an unbroken mismatch run.
         always_ff @(posedge clk) begin
            if (reset) begin
               meta_q      <= 1'b0;
               sync_q      <= 1'b0;
               level_q     <= 1'b0;
               level_dly_q <= 1'b0;
               cnt_q       <= '0;
            end else begin
               meta_q      <= btn_raw[gi];
               sync_q      <= meta_q;
               level_dly_q <= level_q;
               if (sync_q == level_q) begin
                  cnt_q <= '0;
               end else if (cnt_q == DEB_LAST) begin
                  level_q <= sync_q;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
         end

         assign pulse[gi] = level_q & ~level_dly_q;
      end
   endgenerate

   logic [3:0]    sel_q, sel_d;
   logic [4:0]    regidx_q, regidx_d;
   logic [SW-1:0] presc_q, presc_d;
   logic [2:0]    digit_q, digit_d;
   logic [31:0]   snap_q, snap_d;
   logic [7:0]    an_q, an_d;
   logic [7:0]    seg_q, seg_d;

   always_comb begin
      sel_d    = sel_q;
      regidx_d = regidx_q;
      if (pulse[0]) begin
         sel_d = (sel_q == SEL_LAST) ? 4'd0 : sel_q + 4'd1;
      end
      if (pulse[1]) begin
         regidx_d = regidx_q + 5'd1;
      end
   end

   // The snapshot reloads only as the scan returns to digit 0, so a frame is
   // always drawn from one coherent value.
   always_comb begin
      presc_d = presc_q + 1'b1;
      digit_d = digit_q;
      snap_d  = snap_q;
      if (presc_q == PRE_LAST) begin
         presc_d = '0;
         digit_d = digit_q + 3'd1;
         if (digit_q == 3'd7) begin
            snap_d = disdata;
         end
      end
      an_d  = ~(8'b1 << digit_q);
      seg_d = hex_seg(snap_q[{digit_q, 2'b00} +: 4]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q    <= 4'd0;
         regidx_q <= 5'd0;
         presc_q  <= '0;
         digit_q  <= 3'd0;
         snap_q   <= 32'd0;
         an_q     <= 8'hFF;
         seg_q    <= 8'hFF;
      end else begin
         sel_q    <= sel_d;
         regidx_q <= regidx_d;
         presc_q  <= presc_d;
         digit_q  <= digit_d;
         snap_q   <= snap_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
      end
   end

   assign cn3 = {sel_q, regidx_q};
   assign an  = an_q;
   assign seg = seg_q;

endmodule

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Front-panel debug controller for the pipelined MIPS datapath. Two debounced push-buttons drive the 9-bit `cn3` selector consumed by the datapath: `cn3[8:5]` selects the internal signal and `cn3[4:0]` selects the register-file index. The controller snapshots the returned 32-bit `disdata` once per refresh frame and shows it as eight hex digits on a multiplexed, active-low seven-segment display.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required before a button level is accepted (≥2).
- `SCAN_DIV`, default 100000: clock cycles each digit is lit (≥2).
- `NUM_SEL`, default 12: number of signal-select values; `cn3[8:5]` wraps at `NUM_SEL-1`.
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: synchronous, active-high.
- `btn_sel` in 1: raw, asynchronous button; steps the signal select.
- `btn_reg` in 1: raw, asynchronous button; steps the register index.
- `disdata` in 32: value returned by the datapath for the current `cn3`.
- `cn3` out 9: `{sel[3:0], regidx[4:0]}`; registered.
- `an` out 8: digit enables, active-low; bit i is digit i, digit 0 is rightmost.
- `seg` out 8: `{dp,g,f,e,d,c,b,a}`, active-low; `dp` is always 1.

## Operation
- Button path, one instance per button:
  - Two-flop synchronizer feeds `sync`.
  - Counter: if `sync != level`, count increments; if `sync == level`, count clears to 0.
  - When the count reaches `DEBOUNCE_CYCLES-1` and the mismatch is still present, `level <= sync` and the count clears.
  - Pulse = `level & ~level_d`: one cycle per accepted press. Release produces no pulse.
- Selector:
  - On a `btn_sel` pulse, `sel` increments; from `NUM_SEL-1` it wraps to 0.
  - On a `btn_reg` pulse, `regidx` increments mod 32.
  - Both pulses in the same cycle: both fields update.
  - `regidx` is independent of `sel`.
- Scanner:
  - Prescaler runs 0..`SCAN_DIV-1`. At terminal count it returns to 0 and `digit` (3 bits) increments, wrapping 7→0.
  - `snap` (32 bits) loads `disdata` on the same edge where `digit` wraps 7→0. Between wraps, changes on `disdata` are not displayed.
- Outputs, registered every cycle:
  - `an <= ~(8'b1 << digit)`
  - `seg <= {1'b1, hex(snap[4*digit+3 : 4*digit])}`
- Hex decode, 8-bit `seg` values: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.

## Timing
- Reset values:
  - `cn3 = 9'h000`, `an = 8'hFF`, `seg = 8'hFF`.
  - `snap`, `digit`, prescaler, debounce counters, `level`, `level_d` and synchronizers all 0.
- First edge after reset deasserts: `an = 8'hFE`, `seg = 8'hC0` (digit 0 of `snap = 0`).
- Press latency: `cn3` changes on edge k+2+`DEBOUNCE_CYCLES`, where edge k is the first edge sampling the raw button high and the button stays high throughout.
- Any mismatch run shorter than `DEBOUNCE_CYCLES` cycles is discarded.
- Digit dwell is exactly `SCAN_DIV` cycles. A frame is 8·`SCAN_DIV` cycles.
- `an`/`seg` lag `digit`/`snap` by one edge.
- A new `snap` first appears on digit 0, one edge after the wrap.
- Reset asserted mid-press or mid-frame returns all state to reset values on that edge. A button still held after reset must be re-accepted through the full debounce before it produces a pulse.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES=4`, `SCAN_DIV=4`, `NUM_SEL=12`.
- Reset: hold `reset` 3 cycles → `cn3=000`, `an=FF`, `seg=FF`; one edge after release → `an=FE`, `seg=C0`.
- `btn_sel` high 20 cycles, then low → exactly one step, `cn3=9'h020`. 12 clean presses total → `cn3[8:5]` wraps back to 0.
- `btn_sel` toggling every 2 cycles for 30 cycles → `cn3` unchanged.
- `btn_reg` 33 clean presses → `cn3[4:0]=1`. Both buttons pressed on the same edges → `sel` and `regidx` each +1 on the same edge.
- `disdata=32'h0123ABCF` held; after the first frame wrap, digits 0..7 show `seg` 8E, C6, 83, 88, B0, A4, F9, C0 with `an` FE, FD, FB, F7, EF, DF, BF, 7F; each digit lasts 4 cycles.
- Change `disdata` to `32'hFFFFFFFF` mid-frame → the remaining digits of that frame still show the old snapshot; the next frame shows 8E on every digit.
- Assert `reset` during a 2nd-press debounce → `cn3=0` and no pulse, even though the button is still held.
